// File: rtl/l1_bus_arbiter_if.sv
// Request/grant bundle between the per-core L1 ports, the L2-side release and the bus arbiter.
// The arbiter uses the slave modport; L1/L2-side agents drive through the master modport.
interface l1_bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_BITS = 2
);
  logic [NUM_REQ-1:0] req;
  logic               bus_release;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [ID_BITS-1:0] grant_id;
  logic               timeout_err;

  modport master (
    output req, bus_release,
    input  grant, grant_valid, grant_id, timeout_err
  );

  modport slave (
    input  req, bus_release,
    output grant, grant_valid, grant_id, timeout_err
  );
endinterface

// File: rtl/l1_bus_arbiter.sv
// Round-robin owner of the shared L1->L2 bus; grant is held per transaction and released by L2.
// Optional macro ARB_TIMEOUT_EN adds a hold counter that revokes grants held for HOLD_MAX cycles.
module l1_bus_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_BITS  = 2,
  parameter int HOLD_MAX = 255
) (
  input logic              clock,
  input logic              reset,
  l1_bus_arbiter_if.slave  bus
);

  if (HOLD_MAX < 2 || ID_BITS != $clog2(NUM_REQ)) begin : g_cfg_check
    $error("l1_bus_arbiter: HOLD_MAX must be >= 2 and ID_BITS must equal clog2(NUM_REQ)");
  end

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [ID_BITS-1:0] rr_ptr, rr_ptr_nxt;
  logic [NUM_REQ-1:0] grant_p1, grant_nxt;
  logic [ID_BITS-1:0] id_p1, id_nxt;
  logic               vld_p1;
  logic               timeout_hit;
  logic               found;
  logic [ID_BITS-1:0] winner;

  // Explicit wrap so NUM_REQ need not be a power of two.
  function automatic logic [ID_BITS-1:0] wrap_inc(input logic [ID_BITS-1:0] id);
    if (int'(id) >= NUM_REQ - 1) return '0;
    return id + 1'b1;
  endfunction

  function automatic int circ_idx(input logic [ID_BITS-1:0] ptr, input int off);
    int s;
    s = int'(ptr) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s;
  endfunction

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req[circ_idx(rr_ptr, i)]) begin
        found  = 1'b1;
        winner = ID_BITS'(circ_idx(rr_ptr, i));
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_p1;
    id_nxt     = id_p1;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = BUSY;
          grant_nxt = NUM_REQ'(1) << winner;
          id_nxt    = winner;
        end
      end
      BUSY: begin
        // Release, abandonment and timeout all collapse into one exit and one pointer step.
        if (bus.bus_release || !bus.req[id_p1] || timeout_hit) begin
          state_nxt  = IDLE;
          grant_nxt  = '0;
          id_nxt     = '0;
          rr_ptr_nxt = wrap_inc(id_p1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        id_nxt    = '0;
      end
    endcase
  end

  // Stage p1: registered ownership outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_p1 <= '0;
      id_p1    <= '0;
      vld_p1   <= 1'b0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant_p1 <= grant_nxt;
      id_p1    <= id_nxt;
      vld_p1   <= |grant_nxt;
    end
  end

  assign bus.grant       = grant_p1;
  assign bus.grant_valid = vld_p1;
  assign bus.grant_id    = id_p1;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (HOLD_MAX <= 256) ? 8 :
                         (($clog2(HOLD_MAX) > 32) ? 32 : $clog2(HOLD_MAX));

  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_p1;

  // A coincident release wins over the timeout and is treated as a normal completion.
  assign timeout_hit = (state == BUSY) && (hold_cnt == CNT_W'(HOLD_MAX - 1)) && !bus.bus_release;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_cnt   <= '0;
      timeout_p1 <= 1'b0;
    end else begin
      hold_cnt   <= (state == BUSY) ? hold_cnt + 1'b1 : '0;
      timeout_p1 <= timeout_hit;
    end
  end

  assign bus.timeout_err = timeout_p1;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_l1_bus_arbiter.sv
// Scoreboarded bench for l1_bus_arbiter: expected grant ids are queued by each scenario and
// consumed by a monitor on every new grant, which also checks one-hot/stability every cycle.
module tb_l1_bus_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int ID_BITS  = 2;
  localparam int HOLD_MAX = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   exp_q[$];
  logic       prev_valid = 1'b0;
  logic [3:0] prev_grant = 4'b0000;

  l1_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_BITS(ID_BITS)) bus ();

  l1_bus_arbiter #(.NUM_REQ(NUM_REQ), .ID_BITS(ID_BITS), .HOLD_MAX(HOLD_MAX)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Per-cycle invariants plus scoreboard pop on each newly started grant.
  always @(negedge clock) begin
    checks++;
    if ($countones(bus.grant) > 1) begin
      failures++;
      $display("FAIL onehot: grant=%b required at most one bit set", bus.grant);
    end
    checks++;
    if (bus.grant_valid !== (|bus.grant)) begin
      failures++;
      $display("FAIL valid_or: grant_valid=%b required %b", bus.grant_valid, |bus.grant);
    end
    checks++;
    if (bus.grant_valid === 1'b1) begin
      if (bus.grant !== (4'b0001 << bus.grant_id)) begin
        failures++;
        $display("FAIL id_match: grant=%b grant_id=%0d required onehot(id)", bus.grant, bus.grant_id);
      end
    end else if (bus.grant_id !== '0) begin
      failures++;
      $display("FAIL idle_id: grant_id=%0d required 0", bus.grant_id);
    end
    if (prev_valid && bus.grant_valid === 1'b1) begin
      checks++;
      if (bus.grant !== prev_grant) begin
        failures++;
        $display("FAIL hold: grant=%b required %b while busy", bus.grant, prev_grant);
      end
    end
    if (!prev_valid && bus.grant_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: grant_id=%0d required no grant", bus.grant_id);
      end else begin
        int exp_id;
        exp_id = exp_q.pop_front();
        if (int'(bus.grant_id) !== exp_id) begin
          failures++;
          $display("FAIL sb_order: grant_id=%0d required %0d", bus.grant_id, exp_id);
        end
      end
    end
    prev_valid <= (bus.grant_valid === 1'b1);
    prev_grant <= bus.grant;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    bus.req = '0;
    bus.bus_release = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (bus.grant_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.grant_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_wait: grant_valid=%b required 1 within 20 cycles", tag, bus.grant_valid);
    end
  endtask

  task automatic serve(input string tag, input int n, input int hold);
    for (int k = 0; k < n; k++) begin
      wait_grant(tag);
      repeat (hold - 1) tick();
      bus.bus_release = 1'b1;
      tick();
      bus.bus_release = 1'b0;
      checks++;
      if (bus.grant_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s_drop: grant_valid=%b required 0 after release", tag, bus.grant_valid);
      end
    end
  endtask

  task automatic check_drained(input string tag);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drained: %0d grants outstanding required 0", tag, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.req = '0;
    bus.bus_release = 1'b0;
    tick();
    checks++;
    if (bus.grant !== 4'b0 || bus.grant_valid !== 1'b0 || bus.grant_id !== 2'd0 || bus.timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: grant=%b valid=%b id=%0d terr=%b required all 0",
               bus.grant, bus.grant_valid, bus.grant_id, bus.timeout_err);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.grant !== 4'b0 || bus.grant_valid !== 1'b0 || bus.grant_id !== 2'd0) begin
        failures++;
        $display("FAIL idle_noreq: cycle %0d grant=%b valid=%b id=%0d required 0", i,
                 bus.grant, bus.grant_valid, bus.grant_id);
      end
    end
  endtask

  task automatic test_rr_0110;
    apply_reset();
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(1);
    bus.req = 4'b0110;
    serve("rr0110", 3, 3);
    bus.req = '0;
    tick(); tick();
    check_drained("rr0110");
  endtask

  task automatic test_all_req;
    apply_reset();
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    bus.req = 4'b1111;
    serve("all", 5, 4);
    bus.req = '0;
    tick(); tick();
    check_drained("all");
  endtask

  task automatic test_abandon;
    apply_reset();
    exp_q.push_back(3);
    bus.req = 4'b1000;
    wait_grant("abandon");
    tick();
    bus.req = 4'b0111;
    tick();
    checks++;
    if (bus.grant !== 4'b0 || bus.grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL abandon_drop: grant=%b valid=%b required 0", bus.grant, bus.grant_valid);
    end
    exp_q.push_back(0);
    wait_grant("abandon_next");
    bus.bus_release = 1'b1;
    tick();
    bus.bus_release = 1'b0;
    bus.req = '0;
    tick();
    check_drained("abandon");
  endtask

  task automatic test_release_and_abandon;
    apply_reset();
    exp_q.push_back(0);
    bus.req = 4'b0011;
    wait_grant("relab");
    tick();
    bus.bus_release = 1'b1;
    bus.req = 4'b0110;
    tick();
    bus.bus_release = 1'b0;
    checks++;
    if (bus.grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL relab_drop: grant_valid=%b required 0", bus.grant_valid);
    end
    exp_q.push_back(1);
    serve("relab_next", 1, 2);
    bus.req = '0;
    tick();
    check_drained("relab");
  endtask

  task automatic test_idle_release;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      bus.bus_release = 1'b1;
      tick();
      bus.bus_release = 1'b0;
      tick();
      checks++;
      if (bus.grant_valid !== 1'b0 || bus.timeout_err !== 1'b0) begin
        failures++;
        $display("FAIL idle_release: valid=%b terr=%b required 0", bus.grant_valid, bus.timeout_err);
      end
    end
    check_drained("idle_release");
  endtask

  task automatic reset_mid_busy(input logic [3:0] req_after, input int exp_after);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    checks++;
    if (bus.grant !== 4'b0 || bus.grant_valid !== 1'b0 || bus.grant_id !== 2'd0) begin
      failures++;
      $display("FAIL async_reset: grant=%b valid=%b id=%0d required 0",
               bus.grant, bus.grant_valid, bus.grant_id);
    end
    bus.req = req_after;
    tick();
    reset = 1'b0;
    exp_q.push_back(exp_after);
    serve("after_reset", 1, 2);
    bus.req = '0;
    tick();
  endtask

  task automatic test_reset_busy;
    apply_reset();
    exp_q.push_back(1);
    bus.req = 4'b0110;
    serve("rb_pre", 1, 2);
    exp_q.push_back(2);
    wait_grant("rb_busy2");
    reset_mid_busy(4'b0110, 1);
    exp_q.push_back(2);
    bus.req = 4'b0100;
    wait_grant("rb_busy2b");
    reset_mid_busy(4'b0100, 2);
    check_drained("reset_busy");
  endtask

  task automatic test_timeout;
    apply_reset();
    exp_q.push_back(0);
    bus.req = 4'b0001;
    wait_grant("timeout");
`ifdef ARB_TIMEOUT_EN
    repeat (HOLD_MAX - 1) tick();
    checks++;
    if (bus.grant_valid !== 1'b1 || bus.timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL to_held: valid=%b terr=%b required 1/0", bus.grant_valid, bus.timeout_err);
    end
    tick();
    bus.req = '0;
    checks++;
    if (bus.grant_valid !== 1'b0 || bus.timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL to_revoke: valid=%b terr=%b required 0/1", bus.grant_valid, bus.timeout_err);
    end
    tick();
    checks++;
    if (bus.timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL to_pulse: terr=%b required 0", bus.timeout_err);
    end
`else
    repeat (99) tick();
    checks++;
    if (bus.grant_valid !== 1'b1 || bus.grant !== 4'b0001 || bus.timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL hold_100: valid=%b grant=%b terr=%b required 1/0001/0",
               bus.grant_valid, bus.grant, bus.timeout_err);
    end
    bus.bus_release = 1'b1;
    tick();
    bus.bus_release = 1'b0;
    bus.req = '0;
`endif
    tick();
    check_drained("timeout");
  endtask

  initial begin
    bus.req = '0;
    bus.bus_release = 1'b0;
    test_reset();
    test_rr_0110();
    test_all_req();
    test_abandon();
    test_release_and_abandon();
    test_idle_release();
    test_reset_busy();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
